// File: rtl/gray_ptr_rx.sv
// Read-side receiver for a Gray-coded pointer coming from another clock domain.
// It synchronizes and decodes the pointer, tracks a local consumer pointer and fill level, and flags illegal Gray steps.
`timescale 1ns/1ps
module gray_ptr_rx #(
    parameter int DWID        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DWID-1:0] i_gray,
    input  logic            i_rd_inc,
    input  logic            i_err_clr,
    output logic [DWID-1:0] o_bin,
    output logic            o_bin_vld,
    output logic [DWID-1:0] o_rd_ptr,
    output logic [DWID-1:0] o_level,
    output logic            o_empty,
    output logic            o_err
);

    logic [DWID-1:0] sync_q [SYNC_STAGES];
    logic [DWID-1:0] g_s;
    logic [DWID-1:0] g_prev;
    logic [DWID-1:0] g_diff;
    logic            multi_bit;
    logic            rd_accept;

    function automatic logic [DWID-1:0] gray2bin(input logic [DWID-1:0] g);
        logic [DWID-1:0] b;
        b[DWID-1] = g[DWID-1];
        for (int k = DWID - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Plain flop chain: no logic between stages, so each bit settles independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_s    = sync_q[SYNC_STAGES-1];
    assign g_diff = g_s ^ g_prev;
    // More than one bit set exactly when clearing the lowest set bit leaves something behind.
    assign multi_bit = |(g_diff & (g_diff - DWID'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev    <= '0;
            o_bin     <= '0;
            o_bin_vld <= 1'b0;
        end else begin
            g_prev    <= g_s;
            o_bin     <= gray2bin(g_s);
            o_bin_vld <= (g_s != g_prev);
        end
    end

    // A fresh illegal step takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err <= 1'b0;
        end else if (multi_bit) begin
            o_err <= 1'b1;
        end else if (i_err_clr) begin
            o_err <= 1'b0;
        end
    end

    assign rd_accept = i_rd_inc & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_ptr <= '0;
        end else if (rd_accept) begin
            o_rd_ptr <= o_rd_ptr + DWID'(1);
        end
    end

    assign o_level = o_bin - o_rd_ptr;
    assign o_empty = (o_level == '0);

endmodule
